// File: rtl/softmax_reader_if.sv
// Memory read port and output stream of the softmax reader.
// master: the reader (drives address and stream); slave: memory plus consumer.
interface softmax_reader_if #(
    parameter int WIDTH = 64
);
    logic             write_en_bar;
    logic [WIDTH-1:0] data_in_bar;
    logic [31:0]      addr_bar;
    logic [WIDTH-1:0] data_out_bar;

    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready;
    logic             out_last;
    logic [1:0]       out_head;

    modport master (
        output write_en_bar, data_in_bar, addr_bar,
        output out_data, out_valid, out_last, out_head,
        input  data_out_bar, out_ready
    );

    modport slave (
        input  write_en_bar, data_in_bar, addr_bar,
        input  out_data, out_valid, out_last, out_head,
        output data_out_bar, out_ready
    );
endinterface

// File: rtl/softmax_reader.sv
// Streams one softmax job (NUM_WORDS words starting at SOFTMAX_OUTPUT_BASE)
// out of a one-cycle-latency read-only memory port into a valid/ready stream,
// tagging each word with its row-end flag and head index.
// Reads are throttled so that at most two words are ever buffered or in flight.
// Optional feature: define SOFTMAX_READER_CHECKSUM_EN to build a running XOR
// of all transferred words; otherwise checksum is tied to 0.
//
// state | meaning
// IDLE  | waiting for start after reset
// READ  | issuing reads, one per cycle while buffer space allows
// DRAIN | all reads issued, waiting for the stream to empty
// DONE  | job complete, done high until the next start
module softmax_reader #(
    parameter int WIDTH               = 64,
    parameter int SOFTMAX_OUTPUT_BASE = 3072,
    parameter int NUM_WORDS           = 512,
    parameter int ROW_WORDS           = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] checksum,
    softmax_reader_if.master bus
);
    localparam int CNT_W      = $clog2(NUM_WORDS + 1);
    localparam int HEAD_WORDS = NUM_WORDS / 4;

    typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_e;

    state_e           state_q, state_d;
    logic [9:0]       rd_ptr_q, rd_ptr_d;
    logic             inflight_q, inflight_d;
    logic [WIDTH-1:0] fifo_mem_q [2];
    logic [WIDTH-1:0] fifo_mem_d [2];
    logic             fifo_wr_q, fifo_wr_d;
    logic             fifo_rd_q, fifo_rd_d;
    logic [1:0]       fifo_count_q, fifo_count_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic       push;
    logic       pop;
    logic       issue;
    logic       start_job;
    logic [2:0] occupancy;

    assign push      = inflight_q;
    assign pop       = bus.out_valid && bus.out_ready;
    // Buffered words plus the one in flight, minus the one leaving this cycle.
    assign occupancy = 3'(fifo_count_q) + 3'(inflight_q) - 3'(pop);
    assign issue     = (state_q == READ) && (occupancy < 3'd2);

    assign bus.write_en_bar = 1'b0;
    assign bus.data_in_bar  = '0;
    assign bus.addr_bar     = 32'(SOFTMAX_OUTPUT_BASE) + {22'd0, rd_ptr_q};

    assign bus.out_valid = (fifo_count_q != 2'd0);
    assign bus.out_data  = fifo_mem_q[fifo_rd_q];
    assign bus.out_last  = ((count_q % CNT_W'(ROW_WORDS)) == CNT_W'(ROW_WORDS - 1));
    assign bus.out_head  = 2'(count_q / CNT_W'(HEAD_WORDS));

    assign busy = (state_q == READ) || (state_q == DRAIN);
    assign done = (state_q == DONE);

    // Next state, read pointer and job-start pulse.
    always_comb begin
        state_d    = state_q;
        rd_ptr_d   = rd_ptr_q;
        start_job  = 1'b0;
        inflight_d = issue;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d   = READ;
                    rd_ptr_d  = '0;
                    start_job = 1'b1;
                end
            end
            READ: begin
                if (issue) begin
                    if (rd_ptr_q == 10'(NUM_WORDS - 1)) begin
                        state_d = DRAIN;
                    end else begin
                        rd_ptr_d = rd_ptr_q + 10'd1;
                    end
                end
            end
            DRAIN: begin
                // Looks at next-cycle values so done rises right after the last transfer.
                if ((fifo_count_d == 2'd0) && !inflight_d &&
                    ((count_q + CNT_W'(pop)) == CNT_W'(NUM_WORDS))) begin
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Two-entry FIFO: push the returning read word, pop on stream transfer.
    always_comb begin
        fifo_mem_d   = fifo_mem_q;
        fifo_wr_d    = fifo_wr_q;
        fifo_rd_d    = fifo_rd_q;
        fifo_count_d = fifo_count_q + 2'(push) - 2'(pop);
        if (push) begin
            fifo_mem_d[fifo_wr_q] = bus.data_out_bar;
            fifo_wr_d             = ~fifo_wr_q;
        end
        if (pop) begin
            fifo_rd_d = ~fifo_rd_q;
        end
    end

    // Delivered-word counter, cleared when a job starts.
    always_comb begin
        count_d = count_q;
        if (start_job) begin
            count_d = '0;
        end else if (pop) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    // Control and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            rd_ptr_q      <= '0;
            inflight_q    <= 1'b0;
            fifo_mem_q[0] <= '0;
            fifo_mem_q[1] <= '0;
            fifo_wr_q     <= 1'b0;
            fifo_rd_q     <= 1'b0;
            fifo_count_q  <= '0;
            count_q       <= '0;
        end else begin
            state_q      <= state_d;
            rd_ptr_q     <= rd_ptr_d;
            inflight_q   <= inflight_d;
            fifo_mem_q   <= fifo_mem_d;
            fifo_wr_q    <= fifo_wr_d;
            fifo_rd_q    <= fifo_rd_d;
            fifo_count_q <= fifo_count_d;
            count_q      <= count_d;
        end
    end

`ifdef SOFTMAX_READER_CHECKSUM_EN
    logic [WIDTH-1:0] checksum_q, checksum_d;

    // Running XOR of every transferred word, cleared at job start.
    always_comb begin
        checksum_d = checksum_q;
        if (start_job) begin
            checksum_d = '0;
        end else if (pop) begin
            checksum_d = checksum_q ^ bus.out_data;
        end
    end

    // Checksum register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            checksum_q <= '0;
        end else begin
            checksum_q <= checksum_d;
        end
    end

    assign checksum = checksum_q;
`else
    assign checksum = '0;
`endif

endmodule
